mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data RAM between two requesters: IF-stage instruction fetch and MEM-stage load/store.
- Sequences each access through a grant/busy/acknowledge FSM and absorbs multi-cycle RAM latency.
- Drives a pipeline stall while a request is outstanding.
- A watchdog terminates accesses when the RAM never responds.

Parameters:
- TIMEOUT_CYCLES, 16: busy-state cycles without ram_ready before the access is aborted with an error. Legal range 2..255.
- STARVE_LIMIT, 4: consecutive MEM-stage grants allowed while if_req waits. Used only with ARB_STARVE_GUARD_EN. Legal range 1..15.
- ERR_DATA, 32'hDEADBEEF: read data returned on a timed-out access.

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- RST_N  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  32  fetch byte address; stable while if_req is high
- if_rdata  out  32  fetched instruction; valid in the if_ack cycle and held until the next if_ack
- if_ack  out  1  one-cycle completion pulse
- mem_stage_req  in  1  data request; held until mem_stage_ack
- mem_stage_we  in  1  1 = store, 0 = load
- mem_stage_addr  in  32  data byte address
- mem_stage_wdata  in  32  store data
- mem_stage_rdata  out  32  load data; valid in the mem_stage_ack cycle and held until the next mem_stage_ack
- mem_stage_ack  out  1  one-cycle completion pulse
- ram_req  out  1  RAM access strobe
- ram_we  out  1  RAM write enable; 0 on every fetch
- ram_addr  out  32  registered RAM address
- ram_wdata  out  32  registered RAM write data
- ram_rdata  in  32  RAM read data; sampled when ram_ready is high
- ram_ready  in  1  RAM completion
- bus_err  out  1  pulses together with the ack of a timed-out access
- pipe_stall  out  1  combinational: (if_req & ~if_ack) | (mem_stage_req & ~mem_stage_ack)

Behaviour:
- Reset (RST_N low, asynchronous):
  - state = IDLE.
  - ram_req, ram_we, if_ack, mem_stage_ack and bus_err are 0.
  - ram_addr, ram_wdata, if_rdata and mem_stage_rdata are 0.
  - Watchdog and starvation counters are 0.
- Reset during BUSY: the access is abandoned, ram_req drops immediately and no ack is ever issued for that access.
- FSM states: IDLE, BUSY_IF, BUSY_MEM, ACK.
- IDLE:
  - If mem_stage_req is high, latch mem_stage_addr/we/wdata into the ram_* registers and go to BUSY_MEM.
  - Else if if_req is high, latch if_addr with ram_we = 0 and go to BUSY_IF.
  - Else stay in IDLE.
  - The MEM stage has fixed priority because it holds the older instruction.
- BUSY_IF and BUSY_MEM:
  - ram_req = 1 and the watchdog increments each cycle.
  - On an edge where ram_ready = 1:
    - load data: capture ram_rdata into the granted requester's rdata register;
    - store: leave mem_stage_rdata unchanged;
    - go to ACK.
  - If the watchdog reaches TIMEOUT_CYCLES with no ram_ready: load ERR_DATA into the requester's rdata (stores leave rdata unchanged), set the error flag, go to ACK.
- ACK:
  - For exactly one cycle: ram_req = 0, the granted requester's ack = 1, bus_err = error flag.
  - Watchdog clears, error flag clears, next state is IDLE.
  - No grant is made in ACK; a requester that keeps req high with new operands is re-arbitrated in the following IDLE cycle.
- Latency: minimum 3 cycles from request seen in IDLE to ack (IDLE edge → BUSY with ram_ready high → ACK); each RAM wait cycle adds one.
- Simultaneous requests in IDLE: MEM wins; IF waits and pipe_stall stays high.
- ram_addr and ram_wdata stay constant from grant until the return to IDLE.
- Requester inputs changing while a grant is active are ignored.
- Exactly one ack pulse per granted request; if_ack and mem_stage_ack are never high in the same cycle.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - A 4-bit counter increments on each MEM grant made while if_req is high.
  - When the counter equals STARVE_LIMIT, the next IDLE grant goes to IF even if mem_stage_req is high.
  - The counter clears on any IF grant and on any MEM grant made while if_req is low.
- Undefined: strict MEM priority, no counter is instantiated, and if_req may wait indefinitely.

Test Plan:
- Fetch only: if_req = 1, if_addr = 0x40, ram_ready high from the first BUSY cycle, ram_rdata = 0x8C220004 → if_ack pulses in the 3rd cycle, if_rdata = 0x8C220004, ram_we = 0 throughout.
- Store: mem_stage_req = 1, we = 1, addr = 0x100, wdata = 0x12345678, ram_ready delayed 2 cycles → ram_we = 1, ram_addr = 0x100, ram_wdata = 0x12345678; mem_stage_ack in the 5th cycle; mem_stage_rdata unchanged.
- Collision: if_req and a mem_stage_req load asserted in the same IDLE cycle → MEM served first, then IF; pipe_stall = 1 until each ack; the acks are separated by at least 3 cycles.
- Timeout: load request, ram_ready held 0 → after 16 BUSY cycles, mem_stage_ack = 1 and bus_err = 1 in the same cycle, mem_stage_rdata = 0xDEADBEEF.
- Reset mid-access: RST_N low during BUSY_IF → ram_req = 0 immediately, no if_ack; after release, state is IDLE and a new fetch completes normally.
- With ARB_STARVE_GUARD_EN, STARVE_LIMIT = 4: mem_stage_req and if_req held continuously → 4 MEM acks, then 1 IF ack, then MEM again. Without the macro: no IF ack.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundles the IF-stage, MEM-stage and RAM-side signals of mem_port_arbiter.
// slave = arbiter side, master = requesters plus RAM (the environment).
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_stage_req;
  logic        mem_stage_we;
  logic [31:0] mem_stage_addr;
  logic [31:0] mem_stage_wdata;
  logic [31:0] mem_stage_rdata;
  logic        mem_stage_ack;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ready;
  logic        bus_err;
  logic        pipe_stall;

  modport slave (
    input  if_req, if_addr, mem_stage_req, mem_stage_we, mem_stage_addr,
           mem_stage_wdata, ram_rdata, ram_ready,
    output if_rdata, if_ack, mem_stage_rdata, mem_stage_ack, ram_req, ram_we,
           ram_addr, ram_wdata, bus_err, pipe_stall
  );

  modport master (
    output if_req, if_addr, mem_stage_req, mem_stage_we, mem_stage_addr,
           mem_stage_wdata, ram_rdata, ram_ready,
    input  if_rdata, if_ack, mem_stage_rdata, mem_stage_ack, ram_req, ram_we,
           ram_addr, ram_wdata, bus_err, pipe_stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported RAM between instruction fetch and MEM-stage load/store.
// Optional macro ARB_STARVE_GUARD_EN forces an IF grant after STARVE_LIMIT back-to-back MEM grants.
module mem_port_arbiter #(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter int          STARVE_LIMIT   = 4,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input logic            CLK,
  input logic            RST_N,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, ACK} state_t;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15)
  begin : g_param_check
    $error("mem_port_arbiter: TIMEOUT_CYCLES or STARVE_LIMIT out of range");
  end

  state_t      state_q, state_d;
  logic        gnt_mem_q, gnt_mem_d;
  logic        err_q, err_d;
  logic [7:0]  wdog_q, wdog_d;
  logic        ram_we_q, ram_we_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        if_first;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0]  starve_q, starve_d;
  assign if_first = bus.if_req && (starve_q == 4'(STARVE_LIMIT));
`else
  assign if_first = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_mem_d   = gnt_mem_q;
    err_d       = err_q;
    wdog_d      = wdog_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
`ifdef ARB_STARVE_GUARD_EN
    starve_d    = starve_q;
`endif
    case (state_q)
      IDLE: begin
        // MEM holds the older instruction, so it wins unless the starvation guard fires
        if (bus.mem_stage_req && !if_first) begin
          state_d     = BUSY_MEM;
          gnt_mem_d   = 1'b1;
          ram_we_d    = bus.mem_stage_we;
          ram_addr_d  = bus.mem_stage_addr;
          ram_wdata_d = bus.mem_stage_wdata;
`ifdef ARB_STARVE_GUARD_EN
          starve_d    = bus.if_req ? starve_q + 4'd1 : 4'd0;
`endif
        end else if (bus.if_req) begin
          state_d    = BUSY_IF;
          gnt_mem_d  = 1'b0;
          ram_we_d   = 1'b0;
          ram_addr_d = bus.if_addr;
`ifdef ARB_STARVE_GUARD_EN
          starve_d   = 4'd0;
`endif
        end
      end
      BUSY_IF, BUSY_MEM: begin
        if (bus.ram_ready) begin
          if (!ram_we_q) begin
            if (gnt_mem_q) mem_rdata_d = bus.ram_rdata;
            else           if_rdata_d  = bus.ram_rdata;
          end
          state_d = ACK;
        end else if (wdog_q + 8'd1 == 8'(TIMEOUT_CYCLES)) begin
          if (!ram_we_q) begin
            if (gnt_mem_q) mem_rdata_d = ERR_DATA;
            else           if_rdata_d  = ERR_DATA;
          end
          err_d   = 1'b1;
          state_d = ACK;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      ACK: begin
        state_d  = IDLE;
        wdog_d   = 8'd0;
        err_d    = 1'b0;
        ram_we_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      gnt_mem_q   <= 1'b0;
      err_q       <= 1'b0;
      wdog_q      <= 8'd0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= 32'd0;
      ram_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
`ifdef ARB_STARVE_GUARD_EN
      starve_q    <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_mem_q   <= gnt_mem_d;
      err_q       <= err_d;
      wdog_q      <= wdog_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
`ifdef ARB_STARVE_GUARD_EN
      starve_q    <= starve_d;
`endif
    end
  end

  // ram_req decodes from state so an asynchronous reset drops it at once
  assign bus.ram_req         = (state_q == BUSY_IF) || (state_q == BUSY_MEM);
  assign bus.ram_we          = ram_we_q;
  assign bus.ram_addr        = ram_addr_q;
  assign bus.ram_wdata       = ram_wdata_q;
  assign bus.if_rdata        = if_rdata_q;
  assign bus.mem_stage_rdata = mem_rdata_q;
  assign bus.if_ack          = (state_q == ACK) && !gnt_mem_q;
  assign bus.mem_stage_ack   = (state_q == ACK) && gnt_mem_q;
  assign bus.bus_err         = (state_q == ACK) && err_q;
  assign bus.pipe_stall      = (bus.if_req & ~bus.if_ack) | (bus.mem_stage_req & ~bus.mem_stage_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table-driven single transactions,
// then collision, reset-mid-access and sustained-contention sequences.
module tb_mem_port_arbiter;
  localparam int          TMO = 16;
  localparam logic [31:0] ERR = 32'hDEADBEEF;
  localparam logic [31:0] KEY = 32'h5A5A_0000;

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    bit          tmo;
  } txn_t;

  typedef struct {
    bit          is_mem;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        use_fixed;
  logic [31:0] fixed_rdata;
  logic [31:0] model_if, model_mem;
  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  txn_t        tbl[9];

  always #5 CLK = ~CLK;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.TIMEOUT_CYCLES(TMO), .STARVE_LIMIT(4), .ERR_DATA(ERR)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  // RAM model: either a fixed word or a word derived from the address
  always_comb bus.ram_rdata = use_fixed ? fixed_rdata : (bus.ram_addr ^ KEY);

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic push(bit is_mem, bit we, logic [31:0] rd, bit tmo);
    exp_t e;
    logic [31:0] v;
    v = tmo ? ERR : rd;
    if (!we) begin
      if (is_mem) model_mem = v;
      else        model_if  = v;
    end
    e.is_mem = is_mem;
    e.rdata  = is_mem ? model_mem : model_if;
    e.err    = tmo;
    sbq.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (bus.if_ack || bus.mem_stage_ack) begin
      chk1("ack_exclusive", bus.if_ack & bus.mem_stage_ack, 1'b0);
      if (sbq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_ack: got if_ack=%b mem_ack=%b expected none", bus.if_ack, bus.mem_stage_ack);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk1("ack_port_is_mem", bus.mem_stage_ack, e.is_mem);
        chk32("ack_rdata", e.is_mem ? bus.mem_stage_rdata : bus.if_rdata, e.rdata);
        chk1("ack_bus_err", bus.bus_err, e.err);
      end
    end
  end

  // Call just after a rising edge; the current cycle is cycle 1 (IDLE sees the request).
  task automatic do_txn(txn_t t);
    bit got;
    int ack_c;
    use_fixed   = 1'b1;
    fixed_rdata = t.rdata;
    push(t.is_mem, t.we, t.rdata, t.tmo);
    if (t.is_mem) begin
      bus.mem_stage_req   = 1'b1;
      bus.mem_stage_we    = t.we;
      bus.mem_stage_addr  = t.addr;
      bus.mem_stage_wdata = t.wdata;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = t.addr;
    end
    bus.ram_ready = 1'b0;
    got   = 1'b0;
    ack_c = 0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(posedge CLK); #1;
      bus.ram_ready = !t.tmo && (c > t.delay);
      @(negedge CLK);
      if (bus.if_ack || bus.mem_stage_ack) begin
        got   = 1'b1;
        ack_c = c + 1;
        chk1("stall_in_ack", bus.pipe_stall, 1'b0);
      end else begin
        chk1("busy_ram_req", bus.ram_req, 1'b1);
        chk1("busy_ram_we", bus.ram_we, t.is_mem & t.we);
        chk32("busy_ram_addr", bus.ram_addr, t.addr);
        if (t.is_mem && t.we) chk32("busy_ram_wdata", bus.ram_wdata, t.wdata);
        chk1("busy_stall", bus.pipe_stall, 1'b1);
      end
    end
    chk32("ack_latency_cycle", 32'(ack_c), t.tmo ? 32'(TMO + 2) : 32'(t.delay + 3));
    @(posedge CLK); #1;
    bus.if_req        = 1'b0;
    bus.mem_stage_req = 1'b0;
    bus.ram_ready     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish within 200000 time units");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int mem_c, if_c;
    txn_t tr;

    tbl[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,          32'h8C22_0004, 0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'h1234_5678, 32'h0BAD_0BAD, 2, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 32'h0000_0104, 32'h0,          32'hCAFE_F00D, 1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 32'h0000_0108, 32'hA5A5_A5A5, 32'h7777_7777, 0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0,          32'h0000_0013, 3, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 32'h0000_0110, 32'h0,          32'h1111_1111, 0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 32'h0000_0048, 32'h0,          32'h2222_2222, 0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 32'h0000_0114, 32'h5555_AAAA, 32'h3333_3333, 0, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,          32'hFFFF_FFFF, 0, 1'b0};

    RST_N               = 1'b1;
    use_fixed           = 1'b1;
    fixed_rdata         = 32'h0;
    model_if            = 32'h0;
    model_mem           = 32'h0;
    bus.if_req          = 1'b0;
    bus.if_addr         = 32'h0;
    bus.mem_stage_req   = 1'b0;
    bus.mem_stage_we    = 1'b0;
    bus.mem_stage_addr  = 32'h0;
    bus.mem_stage_wdata = 32'h0;
    bus.ram_ready       = 1'b0;
    #2 RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk1("rst_ram_req", bus.ram_req, 1'b0);
    chk1("rst_ram_we", bus.ram_we, 1'b0);
    chk1("rst_if_ack", bus.if_ack, 1'b0);
    chk1("rst_mem_ack", bus.mem_stage_ack, 1'b0);
    chk1("rst_bus_err", bus.bus_err, 1'b0);
    chk32("rst_ram_addr", bus.ram_addr, 32'h0);
    chk32("rst_ram_wdata", bus.ram_wdata, 32'h0);
    chk32("rst_if_rdata", bus.if_rdata, 32'h0);
    chk32("rst_mem_rdata", bus.mem_stage_rdata, 32'h0);
    chk1("rst_stall", bus.pipe_stall, 1'b0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < 9; i++) do_txn(tbl[i]);

    // Collision: MEM load and fetch arrive together
    use_fixed = 1'b0;
    push(1'b1, 1'b0, 32'h0000_0200 ^ KEY, 1'b0);
    push(1'b0, 1'b0, 32'h0000_0080 ^ KEY, 1'b0);
    bus.mem_stage_req  = 1'b1;
    bus.mem_stage_we   = 1'b0;
    bus.mem_stage_addr = 32'h0000_0200;
    bus.if_req         = 1'b1;
    bus.if_addr        = 32'h0000_0080;
    bus.ram_ready      = 1'b1;
    mem_c = 0;
    if_c  = 0;
    for (int c = 1; c <= 30 && if_c == 0; c++) begin
      @(negedge CLK);
      if (bus.mem_stage_ack) mem_c = c;
      if (bus.if_ack)        if_c  = c;
      chk1("coll_stall", bus.pipe_stall, (if_c == 0 && !bus.if_ack) || (mem_c == 0 && !bus.mem_stage_ack));
      @(posedge CLK); #1;
      if (mem_c != 0) bus.mem_stage_req = 1'b0;
      if (if_c != 0)  bus.if_req        = 1'b0;
    end
    bus.ram_ready = 1'b0;
    chk32("coll_mem_ack_cycle", 32'(mem_c), 32'd3);
    chk32("coll_if_ack_cycle", 32'(if_c), 32'd6);
    chk1("coll_ack_gap_ge3", (if_c - mem_c) >= 3, 1'b1);

    // Reset while a fetch is in BUSY_IF
    use_fixed     = 1'b1;
    fixed_rdata   = 32'h1111_1111;
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h0000_0300;
    bus.ram_ready = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk1("rstmid_busy_ram_req", bus.ram_req, 1'b1);
    #2 RST_N = 1'b0;
    #1;
    chk1("rstmid_ram_req_async", bus.ram_req, 1'b0);
    chk32("rstmid_ram_addr", bus.ram_addr, 32'h0);
    bus.if_req = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    model_if  = 32'h0;
    model_mem = 32'h0;
    @(negedge CLK);
    chk1("rstmid_idle_ram_req", bus.ram_req, 1'b0);
    chk32("rstmid_if_rdata", bus.if_rdata, 32'h0);
    @(posedge CLK); #1;
    tr = '{1'b0, 1'b0, 32'h0000_004C, 32'h0, 32'h00A0_0093, 1, 1'b0};
    do_txn(tr);

    // Sustained contention: both requesters hold req high for six completions
    use_fixed = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
    for (int k = 0; k < 4; k++) push(1'b1, 1'b0, 32'h0000_0400 ^ KEY, 1'b0);
    push(1'b0, 1'b0, 32'h0000_0500 ^ KEY, 1'b0);
    push(1'b1, 1'b0, 32'h0000_0400 ^ KEY, 1'b0);
`else
    for (int k = 0; k < 6; k++) push(1'b1, 1'b0, 32'h0000_0400 ^ KEY, 1'b0);
`endif
    bus.mem_stage_req  = 1'b1;
    bus.mem_stage_we   = 1'b0;
    bus.mem_stage_addr = 32'h0000_0400;
    bus.if_req         = 1'b1;
    bus.if_addr        = 32'h0000_0500;
    bus.ram_ready      = 1'b1;
    for (int c = 1; c <= 60 && sbq.size() != 0; c++) begin
      @(posedge CLK); #1;
    end
    bus.mem_stage_req = 1'b0;
    bus.if_req        = 1'b0;
    bus.ram_ready     = 1'b0;
    chk32("starve_drain", 32'(sbq.size()), 32'd0);

    repeat (4) @(posedge CLK);
    #1;
    chk32("final_sb_empty", 32'(sbq.size()), 32'd0);
    chk1("final_ram_req", bus.ram_req, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
